runner_engine: RTL
==================

# runner_engine

Parametrised game engine for the segment-runner display game: generalised successor of the fixed 2-lane, 6-column controller. Supports a configurable lane count and track length, LFSR obstacle generation with a guaranteed-passable track, pause, and level-based speed-up. Sits between the button shapers/authenticator and the score tracker/seven-segment decoder. Exports the obstacle map, player lane, score, level and a one-cycle game-over strobe.

## Interface
- LANES, 2, player rows; legal 2..4
- TRACK_LEN, 6, columns per lane; legal 3..16; column 0 is the player column
- TICK_DIV, 25000000, clock cycles per game tick at level 0; must be ≥ 32
- SPEEDUP_PTS, 10, score points per level increment
- MAX_LEVEL, 7, highest level; must be ≤ 15
- SCORE_W, 14, score width
- Clk  in  1  system clock; all state on rising edge
- Rst  in  1  asynchronous, active-low reset
- Enable  in  1  player logged in; low forces IDLE
- BtGame  in  1  shaped one-cycle pulse: start/pause/resume/acknowledge
- BtUp, BtDown  in  1 each  shaped one-cycle lane-move pulses
- Seed  in  16  LFSR seed, sampled on game start
- Track  out  LANES*TRACK_LEN  bit [l*TRACK_LEN+c] = obstacle in lane l, column c
- PlayerLane  out  max(1,clog2(LANES))  current lane
- GameState  out  2  0 IDLE, 1 RUN, 2 OVER, 3 PAUSE
- GameTick  out  1  one-cycle pulse per track advance
- Score  out  SCORE_W  saturating tick count of current game
- Level  out  4  current speed level
- GameOver  out  1  one-cycle pulse on entry to OVER

## Operation
- Reset: state IDLE; Track, PlayerLane, Score, Level, GameTick, GameOver, tick counter and points counter all 0; LFSR 16'hACE1.
- IDLE: outputs held cleared. BtGame with Enable high → RUN. On this transition the LFSR loads Seed, or 16'hACE1 if Seed==0.
- RUN:
  - Tick counter advances each cycle.
  - Period = TICK_DIV − Level*(TICK_DIV/16).
  - When counter ≥ period−1: counter → 0 and a tick occurs.
- On a tick:
  - Every lane shifts toward column 0; column c ← c+1.
  - LFSR steps once: 16-bit Galois, shift right, XOR mask 16'hB400 when the output bit is 1.
  - New column TRACK_LEN−1 receives exactly one obstacle, in lane (LFSR[7:4] mod LANES), iff LFSR[1:0]==0 and the new column TRACK_LEN−2 is empty. Otherwise it is empty.
  - Invariants: at most one obstacle per column; no two adjacent non-empty columns.
  - Score += 1, saturating at 2^SCORE_W−1.
  - Points counter += 1. On reaching SPEEDUP_PTS it wraps to 0 and Level += 1, saturating at MAX_LEVEL.
- Lane moves (RUN only):
  - BtUp: +1, saturating at LANES−1.
  - BtDown: −1, saturating at 0.
  - Both in the same cycle: no change.
- Collision: checked every RUN cycle on registered Track and PlayerLane. An obstacle at [PlayerLane][0] moves the state to OVER on the next edge. This covers both shifting into the player and the player moving into an obstacle.
- PAUSE: BtGame in RUN → PAUSE. Counter, track, lane and LFSR are frozen. BtGame → RUN, and counting resumes from the frozen value.
- OVER: Track, Score and Level are frozen for display. GameOver is high in the first OVER cycle only. BtGame → IDLE.
- Priority, in every state: Enable low (→ IDLE, no GameOver pulse) > collision > BtGame.
  - Collision and BtGame in the same RUN cycle → OVER.
- A Level change mid-count takes effect immediately through the ≥ comparison. No extra-long period results.

## Timing
- All outputs are registered.
- Edge at which counter==period−1: Track, Score and Level update, and GameTick rises, visible in the following cycle.
- First tick: exactly period cycles after the first RUN cycle.
- Collision: GameState==2 and GameOver==1 one cycle after the colliding Track/PlayerLane are visible.
- Lane move: PlayerLane changes one cycle after the button pulse.
- Enable low: GameState==0 and all outputs cleared one cycle later.
- Asynchronous reset acts immediately mid-game. Rst deassertion is synchronised outside this block.

## Test plan
Bench parameters: TICK_DIV=32, SPEEDUP_PTS=4, LANES=2, TRACK_LEN=6, with a cycle-accurate reference model.
- Start with Seed=0 → LFSR=16'hACE1; first GameTick 32 cycles after RUN entry; Score=1 after it.
- 4 ticks → Level=1; next tick interval 30 cycles. Level saturates at 7 (interval 18) after 28 ticks.
- Seed=16'h1234, hold lane 0 → Track matches model every tick, invariants hold, and the state goes OVER one cycle after the obstacle reaches [0][0]; one GameOver pulse; Score frozen.
- BtGame at counter=10, wait 100 cycles, BtGame → GameState=3 during the wait; next tick 22 cycles after resume.
- BtUp ×3 → lane 1; BtUp+BtDown same cycle → unchanged; BtDown ×2 → lane 0; buttons in IDLE/OVER → ignored.
- Enable low in RUN and in OVER → IDLE next cycle, no GameOver pulse; Rst low mid-RUN → all outputs 0 immediately.

Source files
------------

// File: rtl/runner_engine.sv
// runner_engine: game engine for the segment-runner display game.
// Obstacles scroll toward the player column (column 0) once per game tick; the player dodges
// by changing lane. Obstacles come from a 16-bit Galois LFSR, and placement keeps every
// column to at most one obstacle with an empty column between obstacles, so the track is
// always passable. The tick period shrinks with the level.
//
// Ports:
//   Clk         system clock, rising edge
//   Rst         asynchronous active-low reset
//   Enable      player logged in; low forces IDLE
//   BtGame      one-cycle pulse: start / pause / resume / acknowledge
//   BtUp/BtDown one-cycle lane-move pulses
//   Seed        LFSR seed, sampled on game start (0 selects 16'hACE1)
//   Track       obstacle map, bit [l*TRACK_LEN+c] = lane l, column c
//   PlayerLane  current lane
//   GameState   0 IDLE, 1 RUN, 2 OVER, 3 PAUSE
//   GameTick    one-cycle pulse per track advance
//   Score       saturating tick count of the current game
//   Level       current speed level
//   GameOver    one-cycle pulse on entry to OVER
module runner_engine #(
    parameter int LANES       = 2,
    parameter int TRACK_LEN   = 6,
    parameter int TICK_DIV    = 25000000,
    parameter int SPEEDUP_PTS = 10,
    parameter int MAX_LEVEL   = 7,
    parameter int SCORE_W     = 14,
    localparam int laneW      = (LANES > 2) ? $clog2(LANES) : 1
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic                       Enable,
    input  logic                       BtGame,
    input  logic                       BtUp,
    input  logic                       BtDown,
    input  logic [15:0]                Seed,
    output logic [LANES*TRACK_LEN-1:0] Track,
    output logic [laneW-1:0]           PlayerLane,
    output logic [1:0]                 GameState,
    output logic                       GameTick,
    output logic [SCORE_W-1:0]         Score,
    output logic [3:0]                 Level,
    output logic                       GameOver
);

    localparam int cntW   = $clog2(TICK_DIV);
    localparam int ptsW   = (SPEEDUP_PTS > 1) ? $clog2(SPEEDUP_PTS) : 1;
    localparam int trackW = LANES * TRACK_LEN;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StOver  = 2'd2,
        StPause = 2'd3
    } gameStateT;

    gameStateT          stateQ, stateD;
    logic [trackW-1:0]  trackQ, trackD;
    logic [laneW-1:0]   laneQ, laneD;
    logic [SCORE_W-1:0] scoreQ, scoreD;
    logic [3:0]         levelQ, levelD;
    logic [cntW-1:0]    cntQ, cntD;
    logic [ptsW-1:0]    ptsQ, ptsD;
    logic [15:0]        lfsrQ, lfsrD;
    logic               tickQ, tickD;
    logic               overQ, overD;

    logic [15:0]        lfsrStep;
    logic [31:0]        periodM1;
    logic [31:0]        obsLane;
    logic               tickHit;
    logic               collide;
    logic               topBusy;
    logic               placeObs;

    function automatic logic [15:0] lfsrNext(input logic [15:0] v);
        lfsrNext = {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            stateQ <= StIdle;
            trackQ <= '0;
            laneQ  <= '0;
            scoreQ <= '0;
            levelQ <= '0;
            cntQ   <= '0;
            ptsQ   <= '0;
            lfsrQ  <= 16'hACE1;
            tickQ  <= 1'b0;
            overQ  <= 1'b0;
        end else begin
            stateQ <= stateD;
            trackQ <= trackD;
            laneQ  <= laneD;
            scoreQ <= scoreD;
            levelQ <= levelD;
            cntQ   <= cntD;
            ptsQ   <= ptsD;
            lfsrQ  <= lfsrD;
            tickQ  <= tickD;
            overQ  <= overD;
        end
    end

    always_comb begin
        stateD   = stateQ;
        trackD   = trackQ;
        laneD    = laneQ;
        scoreD   = scoreQ;
        levelD   = levelQ;
        cntD     = cntQ;
        ptsD     = ptsQ;
        lfsrD    = lfsrQ;
        tickD    = 1'b0;
        overD    = 1'b0;
        collide  = 1'b0;
        topBusy  = 1'b0;

        lfsrStep = lfsrNext(lfsrQ);
        // A level bump mid-count shortens the period at once; >= avoids a wrap-around wait.
        periodM1 = 32'(TICK_DIV) - 32'(levelQ) * 32'(TICK_DIV / 16) - 32'd1;
        tickHit  = (32'(cntQ) >= periodM1);
        obsLane  = 32'(lfsrStep[7:4]) % 32'(LANES);

        for (int l = 0; l < LANES; l++) begin
            if (trackQ[l*TRACK_LEN] && (32'(laneQ) == 32'(l))) collide = 1'b1;
            if (trackQ[l*TRACK_LEN + TRACK_LEN - 1]) topBusy = 1'b1;
        end
        // An occupied old top column becomes the new second-to-last one: keep a gap.
        placeObs = (lfsrStep[1:0] == 2'b00) && !topBusy;

        unique case (stateQ)
            StIdle: begin
                if (BtGame) begin
                    stateD = StRun;
                    lfsrD  = (Seed == 16'h0000) ? 16'hACE1 : Seed;
                end
            end
            StRun: begin
                if (collide) begin
                    stateD = StOver;
                end else if (BtGame) begin
                    stateD = StPause;
                end else begin
                    if (BtUp && !BtDown && (32'(laneQ) < 32'(LANES - 1))) begin
                        laneD = laneQ + laneW'(1);
                    end else if (BtDown && !BtUp && (laneQ != '0)) begin
                        laneD = laneQ - laneW'(1);
                    end

                    if (tickHit) begin
                        cntD  = '0;
                        tickD = 1'b1;
                        lfsrD = lfsrStep;
                        for (int l = 0; l < LANES; l++) begin
                            for (int c = 0; c < TRACK_LEN - 1; c++) begin
                                trackD[l*TRACK_LEN + c] = trackQ[l*TRACK_LEN + c + 1];
                            end
                            trackD[l*TRACK_LEN + TRACK_LEN - 1] = placeObs && (obsLane == 32'(l));
                        end
                        if (scoreQ != {SCORE_W{1'b1}}) scoreD = scoreQ + SCORE_W'(1);
                        if (32'(ptsQ) == 32'(SPEEDUP_PTS - 1)) begin
                            ptsD = '0;
                            if (levelQ < 4'(MAX_LEVEL)) levelD = levelQ + 4'd1;
                        end else begin
                            ptsD = ptsQ + ptsW'(1);
                        end
                    end else begin
                        cntD = cntQ + cntW'(1);
                    end
                end
            end
            StPause: begin
                if (BtGame) stateD = StRun;
            end
            StOver: begin
                if (BtGame) stateD = StIdle;
            end
        endcase

        if (!Enable) stateD = StIdle;

        // Every path into IDLE (acknowledge or logout) clears the play state.
        if (stateD == StIdle) begin
            trackD = '0;
            laneD  = '0;
            scoreD = '0;
            levelD = '0;
            cntD   = '0;
            ptsD   = '0;
            tickD  = 1'b0;
        end

        overD = (stateD == StOver) && (stateQ != StOver);
    end

    assign Track      = trackQ;
    assign PlayerLane = laneQ;
    assign GameState  = stateQ;
    assign GameTick   = tickQ;
    assign Score      = scoreQ;
    assign Level      = levelQ;
    assign GameOver   = overQ;

endmodule
